// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared operation encoding for the alu_pipe block.
// Op codes above ALU_OP_LAST are reserved and reported as illegal.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_NOT = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SRA = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_BEQ = 4'd9,
        ALU_BNE = 4'd10,
        ALU_BLT = 4'd11,
        ALU_BGE = 4'd12
    } alu_op_e;

    localparam int unsigned ALU_OP_LAST = 12;

    // True for op codes that map onto a defined operation.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= 4'(ALU_OP_LAST);
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: purely combinational ALU datapath.
// Arithmetic runs at WIDTH+1 bits so the top bit is the carry / no-borrow.
// Optional macro ALU_PIPE_SAT_EN: ADD/SUB saturate on signed overflow
// instead of wrapping; ovf and carry keep their raw meaning.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             carry,
    output logic             take_branch,
    output logic             illegal_op
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   sh;
    logic             a_neg;
    logic             b_neg;
    logic             lt;

    // a - b is formed as a + ~b + 1 so bit WIDTH reads directly as no-borrow.
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign sh    = b[SHW-1:0];
    assign a_neg = a[WIDTH-1];
    assign b_neg = b[WIDTH-1];
    assign lt    = $signed(a) < $signed(b);

    // Operation decode and result/flag selection.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
        f           = '0;
        ovf         = 1'b0;
        carry       = 1'b0;
        take_branch = 1'b0;
        illegal_op  = 1'b0;

        if (!is_legal_op(op)) begin
            illegal_op = 1'b1;
        end else begin
            case (alu_op_e'(op))
                ALU_ADD: begin
                    f     = sum[WIDTH-1:0];
                    carry = sum[WIDTH];
                    ovf   = (a_neg == b_neg) && (sum[WIDTH-1] != a_neg);
                end
                ALU_SUB: begin
                    f     = diff[WIDTH-1:0];
                    carry = diff[WIDTH];
                    ovf   = (a_neg != b_neg) && (diff[WIDTH-1] != a_neg);
                end
                ALU_NOT: f = ~b;
                ALU_AND: f = a & b;
                ALU_OR:  f = a | b;
                ALU_XOR: f = a ^ b;
                // Shift amounts >= WIDTH (non-power-of-2 WIDTH) fall out as all-sign / zero.
                ALU_SRA: f = $signed(a) >>> sh;
                ALU_SLL: f = a << sh;
                ALU_SRL: f = a >> sh;
                ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE: begin
                    f     = diff[WIDTH-1:0];
                    carry = diff[WIDTH];
                    case (alu_op_e'(op))
                        ALU_BEQ: take_branch = (a == b);
                        ALU_BNE: take_branch = (a != b);
                        ALU_BLT: take_branch = lt;
                        default: take_branch = !lt;
                    endcase
                end
                default: ;
            endcase
        end

`ifdef ALU_PIPE_SAT_EN
        // Overflow direction follows the sign of a for both ADD and SUB.
        if (ovf) begin
            f = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        // Wrapping results: the datapath value is used as-is.
`endif
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU stage with valid/ready on both sides and a
// sticky overflow status. One result register, 1-cycle latency, full
// throughput when the consumer is always ready.
// Optional macro ALU_PIPE_SAT_EN (see alu_pipe_core): saturating ADD/SUB.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             carry,
    output logic             zero,
    output logic             take_branch,
    output logic             illegal_op,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    logic             accept;
    logic [WIDTH-1:0] core_f;
    logic             core_ovf;
    logic             core_carry;
    logic             core_take;
    logic             core_illegal;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .op          (op),
        .a           (a),
        .b           (b),
        .f           (core_f),
        .ovf         (core_ovf),
        .carry       (core_carry),
        .take_branch (core_take),
        .illegal_op  (core_illegal)
    );

    // Result register: load on accept, drop valid when drained, otherwise hold.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            // NOTE: the result register is reset (not just valid) because f and flags are visible right after reset.
            out_valid   <= 1'b0;
            f           <= '0;
            ovf         <= 1'b0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            take_branch <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            f           <= core_f;
            ovf         <= core_ovf;
            carry       <= core_carry;
            zero        <= (core_f == '0);
            take_branch <= core_take;
            illegal_op  <= core_illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Sticky overflow: a loading overflow result wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (accept && core_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed literal checks plus randomized traffic compared
// every cycle against an integer-arithmetic reference model.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f;
    logic         ovf;
    logic         carry;
    logic         zero;
    logic         take_branch;
    logic         illegal_op;
    logic         ovf_sticky;
    logic         clr_sticky;

    alu_pipe #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op          (op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .f           (f),
        .ovf         (ovf),
        .carry       (carry),
        .zero        (zero),
        .take_branch (take_branch),
        .illegal_op  (illegal_op),
        .ovf_sticky  (ovf_sticky),
        .clr_sticky  (clr_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] f;
        logic         ovf;
        logic         carry;
        logic         zero;
        logic         take;
        logic         ill;
    } res_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic on the operand values.
    function automatic res_t ref_calc(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int   ua, ub, sa, sb, sh, t;
        res_t r;
        ua = int'(x);
        ub = int'(y);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        sh = ub % 8;
        t  = 0;
        r  = '0;
        case (o)
            4'd0: begin t = sa + sb; r.f = 8'(ua + ub); r.carry = (ua + ub) > 255; r.ovf = (t > 127) || (t < -128); end
            4'd1: begin t = sa - sb; r.f = 8'(ua - ub); r.carry = ua >= ub;        r.ovf = (t > 127) || (t < -128); end
            4'd2: r.f = 8'(255 - ub);
            4'd3: r.f = x & y;
            4'd4: r.f = x | y;
            4'd5: r.f = x ^ y;
            4'd6: r.f = 8'(sa >>> sh);
            4'd7: r.f = 8'(ua << sh);
            4'd8: r.f = 8'(ua >> sh);
            4'd9, 4'd10, 4'd11, 4'd12: begin
                r.f     = 8'(ua - ub);
                r.carry = ua >= ub;
                case (o)
                    4'd9:    r.take = (sa == sb);
                    4'd10:   r.take = (sa != sb);
                    4'd11:   r.take = (sa < sb);
                    default: r.take = (sa >= sb);
                endcase
            end
            default: r.ill = 1'b1;
        endcase
`ifdef ALU_PIPE_SAT_EN
        if (r.ovf) r.f = (t > 127) ? 8'h7F : 8'h80;
`endif
        r.zero = (r.f == 0);
        return r;
    endfunction

    // Model state: what the output side must show after each edge.
    logic          m_init = 1'b0;
    logic          m_valid;
    logic          m_sticky;
    res_t          m_res;
    logic [W-1:0]  sb_q[$];
    int            n_acc;
    int            n_cons;

    // Compare on the falling edge, then advance the model for the next rising edge.
    always @(negedge clk) begin
        res_t r;
        logic acc;
        if (m_init) begin
            check("out_valid", out_valid, m_valid);
            check("in_ready", in_ready, !m_valid || out_ready);
            check("ovf_sticky", ovf_sticky, m_sticky);
            check("f", f, m_res.f);
            check("ovf", ovf, m_res.ovf);
            check("carry", carry, m_res.carry);
            check("zero", zero, m_res.zero);
            check("take_branch", take_branch, m_res.take);
            check("illegal_op", illegal_op, m_res.ill);
            if (out_valid && sb_q.size() > 0) check("sb_order", f, sb_q[0]);
        end
        if (!rst_n) begin
            m_init   = 1'b1;
            m_valid  = 1'b0;
            m_sticky = 1'b0;
            m_res    = '0;
            sb_q.delete();
            n_acc    = 0;
            n_cons   = 0;
        end else begin
            if (in_valid && in_ready) n_acc++;
            if (out_valid && out_ready) n_cons++;
            acc = in_valid && (!m_valid || out_ready);
            r   = ref_calc(op, a, b);
            if (m_valid && out_ready) void'(sb_q.pop_front());
            if (acc) begin
                m_res   = r;
                m_valid = 1'b1;
                sb_q.push_back(r.f);
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (acc && r.ovf) m_sticky = 1'b1;
            else if (clr_sticky) m_sticky = 1'b0;
        end
    end

    task automatic set_in(input logic v, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic rdy);
        in_valid  = v;
        op        = o;
        a         = x;
        b         = y;
        out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_rand;
        int cyc;
        rst_n      = 1'b0;
        clr_sticky = 1'b0;
        set_in(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
        repeat (3) tick();

        // Reset state.
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_f", f, 8'h00);
        check("rst_flags", {ovf, carry, zero, take_branch, illegal_op, ovf_sticky}, 6'b0);
        rst_n = 1'b1;

        // ADD overflow.
        set_in(1'b1, ALU_ADD, 8'h7F, 8'h01, 1'b1); tick();
`ifdef ALU_PIPE_SAT_EN
        check("add_f", f, 8'h7F);
`else
        check("add_f", f, 8'h80);
`endif
        check("add_ovf", ovf, 1'b1);
        check("add_carry", carry, 1'b0);
        check("add_sticky", ovf_sticky, 1'b1);

        // SUB overflow with a coincident sticky clear: set wins.
        clr_sticky = 1'b1;
        set_in(1'b1, ALU_SUB, 8'h80, 8'h01, 1'b1); tick();
`ifdef ALU_PIPE_SAT_EN
        check("sub_f", f, 8'h80);
`else
        check("sub_f", f, 8'h7F);
`endif
        check("sub_ovf", ovf, 1'b1);
        check("sub_carry", carry, 1'b1);
        check("sub_sticky_set_wins", ovf_sticky, 1'b1);

        // Plain clear.
        set_in(1'b1, ALU_AND, 8'h3C, 8'h0F, 1'b1); tick();
        clr_sticky = 1'b0;
        check("and_f", f, 8'h0C);
        check("clr_sticky", ovf_sticky, 1'b0);

        set_in(1'b1, ALU_BLT, 8'hFE, 8'h01, 1'b1); tick();
        check("blt_take", take_branch, 1'b1);
        check("blt_f", f, 8'hFD);
        check("blt_ovf", ovf, 1'b0);

        set_in(1'b1, ALU_SRA, 8'h90, 8'h03, 1'b1); tick();
        check("sra_f", f, 8'hF2);
        set_in(1'b1, ALU_SRL, 8'h90, 8'h03, 1'b1); tick();
        check("srl_f", f, 8'h12);
        set_in(1'b1, ALU_SLL, 8'h81, 8'h09, 1'b1); tick();
        check("sll_f", f, 8'h02);

        set_in(1'b1, 4'd14, 8'h55, 8'h22, 1'b1); tick();
        check("ill_f", f, 8'h00);
        check("ill_flag", illegal_op, 1'b1);
        check("ill_take", take_branch, 1'b0);

        // Backpressure: drain, then hold out_ready low for three cycles.
        set_in(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b1); tick();
        set_in(1'b1, ALU_ADD, 8'h03, 8'h04, 1'b0);
        check("bp_ready_c1", in_ready, 1'b1);
        tick();
        set_in(1'b1, ALU_XOR, 8'h0F, 8'hF0, 1'b0);
        check("bp_ready_c2", in_ready, 1'b0);
        check("bp_f_c2", f, 8'h07);
        tick();
        check("bp_ready_c3", in_ready, 1'b0);
        check("bp_f_c3", f, 8'h07);
        tick();
        check("bp_f_c4", f, 8'h07);
        out_ready = 1'b1;
        tick();
        check("bp_resume_f", f, 8'hFF);
        check("bp_resume_valid", out_valid, 1'b1);

        // Randomized traffic until 50 ops have been accepted.
        n_rand = 0;
        cyc    = 0;
        while (n_rand < 50 && cyc < 1000) begin
            set_in($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   $urandom_range(0, 3) != 0);
            clr_sticky = ($urandom_range(0, 7) == 0);
            #1;
            if (in_valid && in_ready) n_rand++;
            tick();
            cyc++;
        end
        clr_sticky = 1'b0;
        check("rand_budget", n_rand >= 50, 1'b1);

        // Reset while a result is held under backpressure.
        set_in(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b1); tick();
        set_in(1'b1, ALU_ADD, 8'h7F, 8'h01, 1'b0); tick();
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_sticky", ovf_sticky, 1'b1);
        rst_n = 1'b0;
        set_in(1'b1, ALU_ADD, 8'h11, 8'h22, 1'b0); tick();
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_f", f, 8'h00);
        check("mid_rst_flags", {ovf, carry, zero, take_branch, illegal_op, ovf_sticky}, 6'b0);
        rst_n = 1'b1;
        set_in(1'b1, ALU_SUB, 8'h05, 8'h03, 1'b1); tick();
        check("post_rst_f", f, 8'h02);
        check("post_rst_carry", carry, 1'b1);
        check("post_rst_valid", out_valid, 1'b1);

        // Drain and confirm nothing was lost or duplicated.
        set_in(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b1);
        repeat (3) tick();
        check("sb_balance", n_acc - n_cons, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
